// File: rtl/alu_multicycle.sv
// Sequential ALU: single-cycle logic/arith/compare ops, W-cycle shift-add
// multiply and restoring divide, with valid/ready handshakes on both sides.
module alu_multicycle #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   ALUctl,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] ALUout,
  output logic [W-1:0] ALUout_hi,
  output logic         Overflow,
  output logic         Zero,
  output logic         DivZero
);

  localparam int CW = $clog2(W + 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MULU = 4'b0011;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  hi_q, hi_d;      // MULU partial product high / DIVU remainder
  logic [W-1:0]  lo_q, lo_d;      // MULU multiplier shifting out / DIVU quotient shifting in
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  res_lo_q, res_lo_d;
  logic [W-1:0]  res_hi_q, res_hi_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;
  logic          dz_q, dz_d;

  logic [W-1:0]  add_r, sub_r;
  logic [W-1:0]  sc_lo;
  logic          sc_ovf, sc_known;
  logic [W:0]    mul_sum;
  logic [W:0]    div_shift;
  logic          div_ge;
  logic [W-1:0]  hi_step, lo_step;

  assign add_r     = A + B;
  assign sub_r     = A - B;
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign ALUout    = res_lo_q;
  assign ALUout_hi = res_hi_q;
  assign Overflow  = ovf_q;
  assign Zero      = zero_q;
  assign DivZero   = dz_q;

  // Single-cycle result from the live operands; only used on the accept edge.
  always_comb begin
    sc_lo    = '0;
    sc_ovf   = 1'b0;
    sc_known = 1'b1;
    case (ALUctl)
      OP_AND:  sc_lo = A & B;
      OP_OR:   sc_lo = A | B;
      OP_ADD: begin
        sc_lo  = add_r;
        sc_ovf = (A[W-1] == B[W-1]) && (add_r[W-1] != A[W-1]);
      end
      OP_SUB: begin
        sc_lo  = sub_r;
        sc_ovf = (A[W-1] != B[W-1]) && (sub_r[W-1] != A[W-1]);
      end
      OP_SLT:  sc_lo = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: sc_lo = {{(W-1){1'b0}}, (A < B)};
      OP_NOR:  sc_lo = ~(A | B);
      default: sc_known = 1'b0;
    endcase
  end

  // One iteration step: shift-add multiply or restoring divide, sharing hi/lo.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + ({(W+1){lo_q[0]}} & {1'b0, b_q});
    div_shift = {hi_q, lo_q[W-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    hi_step   = '0;
    lo_step   = '0;
    if (op_q == OP_MULU) begin
      hi_step = mul_sum[W:1];
      lo_step = {mul_sum[0], lo_q[W-1:1]};
    end else begin
      // With B == 0 every step "succeeds": quotient becomes all ones and the
      // remainder ends up holding A, which is exactly the divide-by-zero result.
      hi_step = div_ge ? div_shift[W-1:0] - b_q : div_shift[W-1:0];
      lo_step = {lo_q[W-2:0], div_ge};
    end
  end

  // Next-state and result-register logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d = ALUctl;
          if (ALUctl == OP_MULU || ALUctl == OP_DIVU) begin
            b_d     = B;
            hi_d    = '0;
            lo_d    = A;
            cnt_d   = CW'(W);
            state_d = S_ITER;
          end else begin
            res_lo_d = sc_lo;
            res_hi_d = '0;
            ovf_d    = sc_ovf;
            zero_d   = sc_known && (sc_lo == '0);
            dz_d     = 1'b0;
            state_d  = S_DONE;
          end
        end
      end
      S_ITER: begin
        hi_d  = hi_step;
        lo_d  = lo_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_lo_d = lo_step;
          res_hi_d = hi_step;
          ovf_d    = (op_q == OP_MULU) && (hi_step != '0);
          zero_d   = (lo_step == '0);
          dz_d     = (op_q == OP_DIVU) && (b_q == '0);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      dz_q     <= dz_d;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at W=32 and W=8.
module tb_alu_multicycle;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // W=32 instance
  logic        iv32 = 0, ir32, ov32, or32 = 0;
  logic [3:0]  op32 = 0;
  logic [31:0] a32 = 0, b32 = 0, lo32, hi32;
  logic        ovf32, zero32, dz32;

  alu_multicycle #(.W(32)) u32 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv32), .in_ready(ir32),
    .ALUctl(op32), .A(a32), .B(b32), .out_valid(ov32), .out_ready(or32),
    .ALUout(lo32), .ALUout_hi(hi32), .Overflow(ovf32), .Zero(zero32), .DivZero(dz32)
  );

  // W=8 instance
  logic        iv8 = 0, ir8, ov8, or8 = 0;
  logic [3:0]  op8 = 0;
  logic [7:0]  a8 = 0, b8 = 0, lo8, hi8;
  logic        ovf8, zero8, dz8;

  alu_multicycle #(.W(8)) u8 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8),
    .ALUctl(op8), .A(a8), .B(b8), .out_valid(ov8), .out_ready(or8),
    .ALUout(lo8), .ALUout_hi(hi8), .Overflow(ovf8), .Zero(zero8), .DivZero(dz8)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic        ovf;
    logic        zero;
  } vec_t;

  // Present one operation for a single edge (unit assumed idle).
  task automatic send32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    iv32 = 1; op32 = op; a32 = a; b32 = b;
    @(posedge clock); #1;
    iv32 = 0;
  endtask

  task automatic wait32(output int lat, output bit saw_ready);
    lat = 0; saw_ready = 0;
    while (!ov32 && lat < 100) begin
      if (ir32) saw_ready = 1;
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic release32();
    @(negedge clock); or32 = 1;
    @(posedge clock); #1; or32 = 0;
  endtask

  task automatic send8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clock);
    iv8 = 1; op8 = op; a8 = a; b8 = b;
    @(posedge clock); #1;
    iv8 = 0;
  endtask

  task automatic wait8(output int lat);
    lat = 0;
    while (!ov8 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic release8();
    @(negedge clock); or8 = 1;
    @(posedge clock); #1; or8 = 0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    #2;
    total++; if (ov32 !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%b exp=0", ov32); end
    total++; if (ir32 !== 1'b1) begin bad++; $display("FAIL reset in_ready got=%b exp=1", ir32); end
    total++; if ({lo32, hi32} !== 64'h0) begin bad++; $display("FAIL reset outputs got=%h_%h exp=0", hi32, lo32); end
    total++; if ({ovf32, zero32, dz32} !== 3'b000) begin bad++; $display("FAIL reset flags got=%b exp=000", {ovf32, zero32, dz32}); end
    @(negedge clock); @(negedge clock);
    reset_n = 1;
  endtask

  task automatic test_add();
    send32(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    total++; if (ov32 !== 1'b1) begin bad++; $display("FAIL add out_valid got=%b exp=1", ov32); end
    total++; if (lo32 !== 32'h8000_0000) begin bad++; $display("FAIL add ALUout got=%h exp=80000000", lo32); end
    total++; if ({ovf32, zero32, dz32} !== 3'b100) begin bad++; $display("FAIL add flags got=%b exp=100", {ovf32, zero32, dz32}); end
    total++; if (hi32 !== 32'h0) begin bad++; $display("FAIL add ALUout_hi got=%h exp=0", hi32); end
    release32();
    total++; if (ov32 !== 1'b0 || ir32 !== 1'b1) begin bad++; $display("FAIL add release got valid=%b ready=%b exp 0/1", ov32, ir32); end
  endtask

  task automatic test_single_cycle();
    vec_t v[9];
    v[0] = '{4'b0110, 32'd5,          32'd5,          32'h0000_0000, 1'b0, 1'b1};
    v[1] = '{4'b0111, 32'hFFFF_FFFF,  32'd1,          32'h0000_0001, 1'b0, 1'b0};
    v[2] = '{4'b1000, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1'b0, 1'b1};
    v[3] = '{4'b0000, 32'hF0F0_FF00,  32'h0FF0_F0F0,  32'h00F0_F000, 1'b0, 1'b0};
    v[4] = '{4'b0001, 32'hF000_000F,  32'h0000_0F00,  32'hF000_0F0F, 1'b0, 1'b0};
    v[5] = '{4'b1100, 32'hF000_000F,  32'h0000_0F00,  32'h0FFF_F0F0, 1'b0, 1'b0};
    v[6] = '{4'b0110, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF, 1'b1, 1'b0};
    v[7] = '{4'b0010, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1'b0, 1'b1};
    v[8] = '{4'b0101, 32'd3,          32'd3,          32'h0000_0000, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      send32(v[i].op, v[i].a, v[i].b);
      total++;
      if (ov32 !== 1'b1 || lo32 !== v[i].lo || ovf32 !== v[i].ovf || zero32 !== v[i].zero
          || hi32 !== 32'h0 || dz32 !== 1'b0) begin
        bad++;
        $display("FAIL single op=%b got v=%b lo=%h hi=%h ovf=%b z=%b dz=%b exp v=1 lo=%h hi=0 ovf=%b z=%b dz=0",
                 v[i].op, ov32, lo32, hi32, ovf32, zero32, dz32, v[i].lo, v[i].ovf, v[i].zero);
      end
      release32();
    end
  endtask

  task automatic test_mulu();
    int lat; bit sr;
    send32(4'b0011, 32'hFFFF_FFFF, 32'd2);
    total++; if (ir32 !== 1'b0 || ov32 !== 1'b0) begin bad++; $display("FAIL mulu after accept ready=%b valid=%b exp 0/0", ir32, ov32); end
    wait32(lat, sr);
    total++; if (lat != 32) begin bad++; $display("FAIL mulu latency got=%0d exp=32", lat); end
    total++; if (sr) begin bad++; $display("FAIL mulu in_ready during iteration got=1 exp=0"); end
    total++; if (lo32 !== 32'hFFFF_FFFE || hi32 !== 32'h1) begin bad++; $display("FAIL mulu result got=%h_%h exp=00000001_fffffffe", hi32, lo32); end
    total++; if ({ovf32, zero32, dz32} !== 3'b100) begin bad++; $display("FAIL mulu flags got=%b exp=100", {ovf32, zero32, dz32}); end
    release32();
    send32(4'b0011, 32'h0001_0000, 32'h0001_0000);
    wait32(lat, sr);
    total++; if (lo32 !== 32'h0 || hi32 !== 32'h1 || {ovf32, zero32} !== 2'b11) begin
      bad++; $display("FAIL mulu 2^32 got=%h_%h ovf=%b z=%b exp=00000001_00000000 ovf=1 z=1", hi32, lo32, ovf32, zero32); end
    release32();
    send32(4'b0011, 32'd300, 32'd7);
    wait32(lat, sr);
    total++; if (lo32 !== 32'd2100 || hi32 !== 32'h0 || ovf32 !== 1'b0) begin
      bad++; $display("FAIL mulu small got=%h_%h ovf=%b exp=0_834 ovf=0", hi32, lo32, ovf32); end
    release32();
  endtask

  task automatic test_divu();
    int lat; bit sr;
    send32(4'b0100, 32'd100, 32'd7);
    wait32(lat, sr);
    total++; if (lo32 !== 32'd14 || hi32 !== 32'd2) begin bad++; $display("FAIL divu 100/7 got q=%0d r=%0d exp q=14 r=2", lo32, hi32); end
    total++; if ({ovf32, zero32, dz32} !== 3'b000) begin bad++; $display("FAIL divu 100/7 flags got=%b exp=000", {ovf32, zero32, dz32}); end
    release32();
    send32(4'b0100, 32'd9, 32'd0);
    wait32(lat, sr);
    total++; if (lat != 32) begin bad++; $display("FAIL divu by zero latency got=%0d exp=32", lat); end
    total++; if (lo32 !== 32'hFFFF_FFFF || hi32 !== 32'd9 || dz32 !== 1'b1) begin
      bad++; $display("FAIL divu 9/0 got q=%h r=%h dz=%b exp q=ffffffff r=9 dz=1", lo32, hi32, dz32); end
    release32();
    send32(4'b0100, 32'd3, 32'd10);
    wait32(lat, sr);
    total++; if (lo32 !== 32'd0 || hi32 !== 32'd3 || zero32 !== 1'b1) begin
      bad++; $display("FAIL divu 3/10 got q=%h r=%h z=%b exp q=0 r=3 z=1", lo32, hi32, zero32); end
    release32();
  endtask

  task automatic test_backpressure();
    send32(4'b0010, 32'd1, 32'd2);
    @(negedge clock);
    iv32 = 1; op32 = 4'b0110; a32 = 32'd10; b32 = 32'd4;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      total++;
      if (ov32 !== 1'b1 || lo32 !== 32'd3 || ir32 !== 1'b0) begin
        bad++; $display("FAIL backpressure cycle %0d got v=%b lo=%0d rdy=%b exp v=1 lo=3 rdy=0", i, ov32, lo32, ir32);
      end
    end
    @(negedge clock); or32 = 1;
    @(posedge clock); #1;
    or32 = 0;
    total++; if (ov32 !== 1'b0 || ir32 !== 1'b1) begin bad++; $display("FAIL backpressure release got v=%b rdy=%b exp 0/1", ov32, ir32); end
    @(posedge clock); #1;
    iv32 = 0;
    total++; if (ov32 !== 1'b1 || lo32 !== 32'd6) begin bad++; $display("FAIL backpressure next op got v=%b lo=%0d exp v=1 lo=6", ov32, lo32); end
    release32();
  endtask

  task automatic test_reset_mid();
    int lat; bit sr;
    send32(4'b0011, 32'hFFFF_FFFF, 32'd2);
    for (int i = 0; i < 10; i++) begin @(posedge clock); #1; end
    reset_n = 0;
    #1;
    total++; if (ov32 !== 1'b0 || {lo32, hi32} !== 64'h0 || {ovf32, zero32, dz32} !== 3'b000) begin
      bad++; $display("FAIL reset mid-op got v=%b out=%h_%h flags=%b exp all 0", ov32, hi32, lo32, {ovf32, zero32, dz32}); end
    total++; if (ir32 !== 1'b1) begin bad++; $display("FAIL reset mid-op in_ready got=%b exp=1", ir32); end
    @(negedge clock); reset_n = 1;
    @(posedge clock); #1;
    total++; if (ov32 !== 1'b0) begin bad++; $display("FAIL reset mid-op stale result got v=1 exp=0"); end
    send32(4'b0100, 32'd100, 32'd7);
    wait32(lat, sr);
    total++; if (lat != 32 || lo32 !== 32'd14 || hi32 !== 32'd2) begin
      bad++; $display("FAIL divu after reset got lat=%0d q=%0d r=%0d exp lat=32 q=14 r=2", lat, lo32, hi32); end
    release32();
  endtask

  task automatic test_w8();
    int lat;
    send8(4'b0011, 8'hFF, 8'd2);
    total++; if (ir8 !== 1'b0) begin bad++; $display("FAIL w8 mulu in_ready got=%b exp=0", ir8); end
    wait8(lat);
    total++; if (lat != 8) begin bad++; $display("FAIL w8 mulu latency got=%0d exp=8", lat); end
    total++; if (lo8 !== 8'hFE || hi8 !== 8'h01 || ovf8 !== 1'b1) begin
      bad++; $display("FAIL w8 mulu got=%h_%h ovf=%b exp=01_fe ovf=1", hi8, lo8, ovf8); end
    release8();
    send8(4'b0100, 8'd100, 8'd7);
    wait8(lat);
    total++; if (lat != 8 || lo8 !== 8'd14 || hi8 !== 8'd2 || dz8 !== 1'b0) begin
      bad++; $display("FAIL w8 divu 100/7 got lat=%0d q=%0d r=%0d dz=%b exp lat=8 q=14 r=2 dz=0", lat, lo8, hi8, dz8); end
    release8();
    send8(4'b0100, 8'd9, 8'd0);
    wait8(lat);
    total++; if (lo8 !== 8'hFF || hi8 !== 8'd9 || dz8 !== 1'b1) begin
      bad++; $display("FAIL w8 divu 9/0 got q=%h r=%h dz=%b exp q=ff r=09 dz=1", lo8, hi8, dz8); end
    release8();
  endtask

  initial begin
    test_reset();
    test_add();
    test_single_cycle();
    test_mulu();
    test_divu();
    test_backpressure();
    test_reset_mid();
    test_w8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
